// File: rtl/flash_rom_arbiter.sv
// Two-requester read arbiter for an asynchronous parallel NOR flash holding AGC fixed memory.
// Define FLASH_ARB_ROUND_ROBIN_EN for alternating priority; otherwise requester A always wins ties.
module flash_rom_arbiter #(
  parameter int ACCESS_CYCLES = 4,
  parameter int TURN_CYCLES   = 1
) (
  input  logic        SIM_CLK,
  input  logic        SIM_RST,
  input  logic        A_REQ,
  input  logic [16:0] A_ADDR,
  output logic        A_ACK,
  output logic [15:0] A_DATA,
  input  logic        B_REQ,
  input  logic [16:0] B_ADDR,
  output logic        B_ACK,
  output logic [15:0] B_DATA,
  output logic [16:0] FL_ADDR,
  output logic        FL_CE_n,
  output logic        FL_OE_n,
  output logic        FL_WE_n,
  input  logic [15:0] FL_DQ
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SENSE = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [3:0] ACCESS_LOAD = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] TURN_LOAD   = 4'(TURN_CYCLES - 1);

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        ce_n_r, ce_n_s;
  logic        oe_n_r, oe_n_s;
  logic [16:0] addr_r, addr_s;
  logic        a_ack_r, a_ack_s;
  logic        b_ack_r, b_ack_s;
  logic [15:0] a_data_r, a_data_s;
  logic [15:0] b_data_r, b_data_s;
  logic        win_b_r, win_b_s;
  logic        pick_b_s;

`ifdef FLASH_ARB_ROUND_ROBIN_EN
  // ptr_r = 1 favours B on a tie; it always points away from the last winner
  logic ptr_r, ptr_s;

  // Arbitration with rotating priority
  always_comb begin
    pick_b_s = B_REQ && (!A_REQ || ptr_r);
  end

  // Pointer update on every grant
  always_comb begin
    ptr_s = ptr_r;
    if (state_r == IDLE && (A_REQ || B_REQ)) begin
      ptr_s = ~pick_b_s;
    end else begin
      ptr_s = ptr_r;
    end
  end

  // Priority pointer register
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      ptr_r <= 1'b0;
    end else begin
      ptr_r <= ptr_s;
    end
  end
`else
  // Fixed priority: B only wins when A is idle
  always_comb begin
    pick_b_s = B_REQ && !A_REQ;
  end
`endif

  // Next-state and next-output logic
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    ce_n_s   = ce_n_r;
    oe_n_s   = oe_n_r;
    addr_s   = addr_r;
    a_ack_s  = 1'b0;
    b_ack_s  = 1'b0;
    a_data_s = a_data_r;
    b_data_s = b_data_r;
    win_b_s  = win_b_r;
    case (state_r)
      IDLE: begin
        if (A_REQ || B_REQ) begin
          win_b_s = pick_b_s;
          addr_s  = pick_b_s ? B_ADDR : A_ADDR;
          ce_n_s  = 1'b0;
          state_s = SETUP;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        oe_n_s  = 1'b0;
        cnt_s   = ACCESS_LOAD;
        state_s = SENSE;
      end
      SENSE: begin
        if (cnt_r == 4'd0) begin
          if (win_b_r) begin
            b_data_s = FL_DQ;
            b_ack_s  = 1'b1;
          end else begin
            a_data_s = FL_DQ;
            a_ack_s  = 1'b1;
          end
          ce_n_s  = 1'b1;
          oe_n_s  = 1'b1;
          cnt_s   = TURN_LOAD;
          state_s = GAP;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      GAP: begin
        if (cnt_r == 4'd0) begin
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
        ce_n_s  = 1'b1;
        oe_n_s  = 1'b1;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      ce_n_r   <= 1'b1;
      oe_n_r   <= 1'b1;
      addr_r   <= 17'd0;
      a_ack_r  <= 1'b0;
      b_ack_r  <= 1'b0;
      a_data_r <= 16'd0;
      b_data_r <= 16'd0;
      win_b_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      ce_n_r   <= ce_n_s;
      oe_n_r   <= oe_n_s;
      addr_r   <= addr_s;
      a_ack_r  <= a_ack_s;
      b_ack_r  <= b_ack_s;
      a_data_r <= a_data_s;
      b_data_r <= b_data_s;
      win_b_r  <= win_b_s;
    end
  end

  assign FL_ADDR = addr_r;
  assign FL_CE_n = ce_n_r;
  assign FL_OE_n = oe_n_r;
  assign FL_WE_n = 1'b1;
  assign A_ACK   = a_ack_r;
  assign B_ACK   = b_ack_r;
  assign A_DATA  = a_data_r;
  assign B_DATA  = b_data_r;

endmodule

// File: tb/tb_flash_rom_arbiter.sv
// Scoreboard bench for flash_rom_arbiter: a default instance plus an ACCESS=1/TURN=15 corner instance.
module tb_flash_rom_arbiter;

  typedef struct {
    bit          is_b;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic        SIM_CLK;
  logic        SIM_RST;
  logic        A_REQ, B_REQ;
  logic [16:0] A_ADDR, B_ADDR;
  logic        A_ACK, B_ACK;
  logic [15:0] A_DATA, B_DATA;
  logic [16:0] FL_ADDR;
  logic        FL_CE_n, FL_OE_n, FL_WE_n;
  logic [15:0] FL_DQ;

  logic        c_a_req, c_b_req;
  logic [16:0] c_a_addr, c_b_addr;
  logic        c_a_ack, c_b_ack;
  logic [15:0] c_a_data, c_b_data;
  logic [16:0] c_fl_addr;
  logic        c_ce_n, c_oe_n, c_we_n;
  logic [15:0] c_fl_dq;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] a_model = 16'h0000;
  logic [15:0] b_model = 16'h0000;

  flash_rom_arbiter dut (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST),
    .A_REQ(A_REQ), .A_ADDR(A_ADDR), .A_ACK(A_ACK), .A_DATA(A_DATA),
    .B_REQ(B_REQ), .B_ADDR(B_ADDR), .B_ACK(B_ACK), .B_DATA(B_DATA),
    .FL_ADDR(FL_ADDR), .FL_CE_n(FL_CE_n), .FL_OE_n(FL_OE_n), .FL_WE_n(FL_WE_n),
    .FL_DQ(FL_DQ)
  );

  flash_rom_arbiter #(.ACCESS_CYCLES(1), .TURN_CYCLES(15)) dut_corner (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST),
    .A_REQ(c_a_req), .A_ADDR(c_a_addr), .A_ACK(c_a_ack), .A_DATA(c_a_data),
    .B_REQ(c_b_req), .B_ADDR(c_b_addr), .B_ACK(c_b_ack), .B_DATA(c_b_data),
    .FL_ADDR(c_fl_addr), .FL_CE_n(c_ce_n), .FL_OE_n(c_oe_n), .FL_WE_n(c_we_n),
    .FL_DQ(c_fl_dq)
  );

  initial begin
    SIM_CLK = 1'b0;
    forever #5 SIM_CLK = ~SIM_CLK;
  end

  always @(posedge SIM_CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge SIM_CLK);
    #1;
  endtask

  // Monitor: protocol invariants and scoreboard for both instances
  always @(negedge SIM_CLK) begin
    exp_t e;
    check("oe_while_ce_high", {31'd0, (!FL_OE_n && FL_CE_n) || (!c_oe_n && c_ce_n)}, 32'd0);
    check("we_n_const", {30'd0, FL_WE_n, c_we_n}, 32'd3);
    if (A_ACK || B_ACK) begin
      check("dual_ack", {31'd0, A_ACK && B_ACK}, 32'd0);
      if (q0.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = q0.pop_front();
        check("ack_who", {31'd0, B_ACK}, {31'd0, e.is_b});
        check("ack_cycle", cyc, e.cyc);
        if (e.is_b) b_model = e.data;
        else        a_model = e.data;
        check("a_data", {16'd0, A_DATA}, {16'd0, a_model});
        check("b_data", {16'd0, B_DATA}, {16'd0, b_model});
      end
    end
    if (c_a_ack || c_b_ack) begin
      if (q1.size() == 0) begin
        check("corner_unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        check("corner_ack_who", {31'd0, c_b_ack}, {31'd0, e.is_b});
        check("corner_ack_cycle", cyc, e.cyc);
        check("corner_a_data", {16'd0, c_a_data}, {16'd0, e.data});
      end
    end
  end

  // One isolated fetch; chg_c >= 0 moves the requester's address mid-access
  task automatic single(input bit use_b, input logic [16:0] addr, input logic [15:0] data,
                        input int chg_c);
    int k;
    step();
    k = cyc;
    if (use_b) begin B_REQ = 1'b1; B_ADDR = addr; end
    else       begin A_REQ = 1'b1; A_ADDR = addr; end
    FL_DQ = data;
    q0.push_back('{use_b, data, k + 6});
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) step();
      if (c == chg_c) begin
        if (use_b) B_ADDR = 17'h1FFFF;
        else       A_ADDR = 17'h1FFFF;
      end
      if (c == 6) begin A_REQ = 1'b0; B_REQ = 1'b0; end
      @(negedge SIM_CLK);
      check("fetch_ce_n", {31'd0, FL_CE_n}, (c >= 1 && c <= 5) ? 32'd0 : 32'd1);
      check("fetch_oe_n", {31'd0, FL_OE_n}, (c >= 2 && c <= 5) ? 32'd0 : 32'd1);
      if (c >= 1) check("fetch_addr", {15'd0, FL_ADDR}, {15'd0, addr});
    end
  endtask

  initial begin
    int   k;
    int   m;
    bit   exp_b;
    SIM_RST = 1'b1;
    A_REQ = 1'b0; B_REQ = 1'b0; A_ADDR = 17'd0; B_ADDR = 17'd0; FL_DQ = 16'd0;
    c_a_req = 1'b0; c_b_req = 1'b0; c_a_addr = 17'd0; c_b_addr = 17'd0; c_fl_dq = 16'd0;
    #1 SIM_RST = 1'b0;
    #2;
    check("rst_ce_n", {31'd0, FL_CE_n}, 32'd1);
    check("rst_oe_n", {31'd0, FL_OE_n}, 32'd1);
    check("rst_we_n", {31'd0, FL_WE_n}, 32'd1);
    check("rst_fl_addr", {15'd0, FL_ADDR}, 32'd0);
    check("rst_acks", {30'd0, A_ACK, B_ACK}, 32'd0);
    check("rst_data", {A_DATA, B_DATA}, 32'd0);
    check("rst_corner_en", {30'd0, c_ce_n, c_oe_n}, 32'd3);
    #19 SIM_RST = 1'b1;
    repeat (2) step();

    single(1'b0, 17'h00123, 16'hBEEF, -1);
    single(1'b1, 17'h0ABCD, 16'h1234, -1);

    // Contention: both held for four grants, 7-cycle grant period
    step();
    k = cyc;
    A_REQ = 1'b1; B_REQ = 1'b1; A_ADDR = 17'h00200; B_ADDR = 17'h00300; FL_DQ = 16'hC0DE;
    for (int g = 0; g < 4; g++) begin
`ifdef FLASH_ARB_ROUND_ROBIN_EN
      exp_b = (g % 2) == 1;
`else
      exp_b = 1'b0;
`endif
      q0.push_back('{exp_b, 16'hC0DE, k + 6 + 7 * g});
    end
    for (int c = 0; c <= 28; c++) begin
      if (c > 0) step();
      if (c == 27) begin A_REQ = 1'b0; B_REQ = 1'b0; end
      @(negedge SIM_CLK);
      check("cont_ce_n", {31'd0, FL_CE_n}, (c % 7 == 0 || c % 7 == 6) ? 32'd1 : 32'd0);
      if (c % 7 == 1) begin
`ifdef FLASH_ARB_ROUND_ROBIN_EN
        check("cont_addr", {15'd0, FL_ADDR}, ((c / 7) % 2 == 1) ? 32'h300 : 32'h200);
`else
        check("cont_addr", {15'd0, FL_ADDR}, 32'h200);
`endif
      end
    end

    single(1'b0, 17'h00010, 16'h5A5A, 3);

    // Reset in the middle of SENSE aborts without ACK
    step();
    A_REQ = 1'b1; A_ADDR = 17'h00777; FL_DQ = 16'hDEAD;
    repeat (3) step();
    #2 SIM_RST = 1'b0;
    #1;
    check("abort_ce_n", {31'd0, FL_CE_n}, 32'd1);
    check("abort_oe_n", {31'd0, FL_OE_n}, 32'd1);
    check("abort_ack", {31'd0, A_ACK}, 32'd0);
    check("abort_data", {16'd0, A_DATA}, 32'd0);
    check("abort_fl_addr", {15'd0, FL_ADDR}, 32'd0);
    a_model = 16'h0000;
    b_model = 16'h0000;
    @(negedge SIM_CLK);
    step();
    @(negedge SIM_CLK);
    SIM_RST = 1'b1;
    m = cyc;
    q0.push_back('{1'b0, 16'hDEAD, m + 6});
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c == 6) A_REQ = 1'b0;
      @(negedge SIM_CLK);
      check("refetch_ce_n", {31'd0, FL_CE_n}, (c <= 5) ? 32'd0 : 32'd1);
    end

    // Corner: ACCESS_CYCLES=1, TURN_CYCLES=15, A held for two grants
    step();
    k = cyc;
    c_a_req = 1'b1; c_a_addr = 17'h1ABCD; c_fl_dq = 16'h7E57;
    q1.push_back('{1'b0, 16'h7E57, k + 3});
    q1.push_back('{1'b0, 16'h7E57, k + 21});
    for (int c = 0; c <= 22; c++) begin
      if (c > 0) step();
      if (c == 21) c_a_req = 1'b0;
      @(negedge SIM_CLK);
      check("corner_ce_n", {31'd0, c_ce_n},
            (c == 1 || c == 2 || c == 19 || c == 20) ? 32'd0 : 32'd1);
      check("corner_oe_n", {31'd0, c_oe_n}, (c == 2 || c == 20) ? 32'd0 : 32'd1);
      if (c >= 1) check("corner_addr", {15'd0, c_fl_addr}, 32'h1ABCD);
    end

    repeat (3) step();
    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
